// File: rtl/wb_arbiter.sv
// wb_arbiter: merges two ALU result pipes and an in-order load-result buffer onto
// two register-file write ports, with load cancellation and a starvation drain.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu1_valid,
    input  logic [4:0]  alu1_reg,
    input  logic [31:0] alu1_data,
    input  logic        alu2_valid,
    input  logic [4:0]  alu2_reg,
    input  logic [31:0] alu2_data,
    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        WE1,
    output logic        WE2,
    output logic [4:0]  WriteReg1,
    output logic [4:0]  WriteReg2,
    output logic [31:0] ResultW1,
    output logic [31:0] ResultW2,
    output logic [31:0] pending_mask,
    output logic        stall_alu,
    output logic [0:0]  dbg_state
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIM_M1  = SW'(STARVE_LIM - 1);

    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] DRAIN  = 1'b1;

    logic [4:0]            ent_reg  [FIFO_DEPTH];
    logic [31:0]           ent_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_live;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    logic [FIFO_DEPTH-1:0] occupied;
    logic [FIFO_DEPTH-1:0] live_eff;
    logic [FIFO_DEPTH-1:0] live_next;
    logic [31:0]           pend_next;
    logic [CW-1:0]         count_next;
    logic [PW-1:0]         h0;
    logic [PW-1:0]         h1;
    logic                  push;
    logic                  has_live;

    logic                  pop0;
    logic                  pop1;
    logic                  use1;
    logic                  use2;
    logic [PW-1:0]         slot1;
    logic [PW-1:0]         slot2;
    logic                  p1_open;
    logic                  p2_open;

    logic                  p1_we;
    logic                  p2_we;
    logic [4:0]            p1_reg;
    logic [4:0]            p2_reg;
    logic [31:0]           p1_data;
    logic [31:0]           p2_data;
    logic                  waw;

    logic [0:0]            state;
    logic [0:0]            state_next;
    logic [SW-1:0]         cnt;
    logic [SW-1:0]         cnt_next;
    logic                  stall_next;

    assign h0 = rd_ptr;
    assign h1 = rd_ptr + PW'(1);

    // A buffered load is killed when an ALU result for the same register is
    // retiring now: that ALU write is guaranteed younger than the load.
    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_slot
        logic [PW-1:0] off;
        logic          kill;
        assign off         = PW'(g) - rd_ptr;
        assign occupied[g] = CW'(off) < count;
        assign kill        = (alu1_valid && (ent_reg[g] == alu1_reg)) ||
                             (alu2_valid && (ent_reg[g] == alu2_reg));
        assign live_eff[g] = ent_live[g] && occupied[g] && !kill;
    end

    assign has_live = |live_eff;

    // Walk the two oldest entries in order: dead ones are dropped for free,
    // live ones take the oldest still-open port, and a blocked live entry stops the walk.
    always_comb begin
        p1_open = !alu1_valid;
        p2_open = !alu2_valid;
        pop0    = 1'b0;
        pop1    = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        slot1   = h0;
        slot2   = h0;
        if (count >= CW'(1)) begin
            if (!live_eff[h0]) begin
                pop0 = 1'b1;
            end else if (p1_open) begin
                pop0    = 1'b1;
                use1    = 1'b1;
                slot1   = h0;
                p1_open = 1'b0;
            end else if (p2_open) begin
                pop0    = 1'b1;
                use2    = 1'b1;
                slot2   = h0;
                p2_open = 1'b0;
            end
        end
        if (pop0 && (count >= CW'(2))) begin
            if (!live_eff[h1]) begin
                pop1 = 1'b1;
            end else if (p1_open) begin
                pop1    = 1'b1;
                use1    = 1'b1;
                slot1   = h1;
                p1_open = 1'b0;
            end else if (p2_open) begin
                pop1    = 1'b1;
                use2    = 1'b1;
                slot2   = h1;
                p2_open = 1'b0;
            end
        end
    end

    always_comb begin
        p1_we   = 1'b0;
        p1_reg  = 5'd0;
        p1_data = 32'd0;
        if (alu1_valid) begin
            p1_we   = (alu1_reg != 5'd0);
            p1_reg  = alu1_reg;
            p1_data = alu1_data;
        end else if (use1) begin
            p1_we   = 1'b1;
            p1_reg  = ent_reg[slot1];
            p1_data = ent_data[slot1];
        end
    end

    always_comb begin
        p2_we   = 1'b0;
        p2_reg  = 5'd0;
        p2_data = 32'd0;
        if (alu2_valid) begin
            p2_we   = (alu2_reg != 5'd0);
            p2_reg  = alu2_reg;
            p2_data = alu2_data;
        end else if (use2) begin
            p2_we   = 1'b1;
            p2_reg  = ent_reg[slot2];
            p2_data = ent_data[slot2];
        end
    end

    // Port 2 always carries the younger value, so it wins a same-register collision.
    assign waw = p1_we && p2_we && (p1_reg == p2_reg);

    // mem_valid/mem_ready: a load transfers on a rising edge where both are high;
    // mem_valid may be held while mem_ready is low; register-0 loads transfer but are dropped.
    assign push       = mem_valid && mem_ready && (mem_reg != 5'd0) && (count < DEPTH_C);
    assign count_next = count + CW'(push) - CW'(pop0) - CW'(pop1);

    always_comb begin
        live_next = live_eff;
        if (pop0) live_next[h0] = 1'b0;
        if (pop1) live_next[h1] = 1'b0;
        if (push) live_next[wr_ptr] = 1'b1;
    end

    always_comb begin
        pend_next = 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live_next[i]) begin
                pend_next[(push && (wr_ptr == PW'(i))) ? mem_reg : ent_reg[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ent_live <= '0;
        end else begin
            rd_ptr   <= rd_ptr + PW'(pop0) + PW'(pop1);
            wr_ptr   <= wr_ptr + PW'(push);
            count    <= count_next;
            ent_live <= live_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_reg[wr_ptr]  <= mem_reg;
            ent_data[wr_ptr] <= mem_data;
        end
    end

    // Starvation: consecutive cycles where both ALUs hold the ports while a live load waits.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_next = 1'b0;
        case (state)
            NORMAL: begin
                if (alu1_valid && alu2_valid && has_live) begin
                    if (cnt >= LIM_M1) begin
                        state_next = DRAIN;
                        stall_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + SW'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = NORMAL;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE1          <= 1'b0;
            WE2          <= 1'b0;
            WriteReg1    <= 5'd0;
            WriteReg2    <= 5'd0;
            ResultW1     <= 32'd0;
            ResultW2     <= 32'd0;
            mem_ready    <= 1'b0;
            pending_mask <= 32'd0;
            stall_alu    <= 1'b0;
        end else begin
            WE1          <= p1_we && !waw;
            WE2          <= p2_we;
            WriteReg1    <= p1_reg;
            WriteReg2    <= p2_reg;
            ResultW1     <= p1_data;
            ResultW2     <= p2_data;
            mem_ready    <= (count_next < DEPTH_C);
            pending_mask <= pend_next;
            stall_alu    <= stall_next;
        end
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, load-result buffer entries (power of 2, 2..16).
REQ-002 Parameter STARVE_LIM, default 8, consecutive blocked cycles before forced drain.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 alu1_valid, alu2_valid  input  1 each  ALU pipe 1 / pipe 2 result valid this cycle.
REQ-006 alu1_reg, alu2_reg  input  5 each  destination register.
REQ-007 alu1_data, alu2_data  input  32 each  result value.
REQ-008 mem_valid  input  1  load result offered by cache/memory stage.
REQ-009 mem_reg  input  5; mem_data  input  32  load destination and value.
REQ-010 mem_ready  output  1  load result accepted when mem_valid && mem_ready at clock edge.
REQ-011 WE1, WE2  output  1 each  register-file write enables.
REQ-012 WriteReg1, WriteReg2  output  5 each; ResultW1, ResultW2  output  32 each  write address/data.
REQ-013 pending_mask  output  32  bit r set while a load to register r is buffered.
REQ-014 stall_alu  output  1  request to hold both ALU pipes for one cycle.

Function
REQ-015 All outputs registered; port outputs reflect inputs sampled one cycle earlier (latency 1).
REQ-016 ALU results are never back-pressured except via stall_alu; when stall_alu=1, upstream guarantees alu1_valid=alu2_valid=0 next cycle.
REQ-017 Loads are pushed to an in-order FIFO; mem_ready = (count < FIFO_DEPTH) evaluated from registered count, with pop in same cycle not counted.
REQ-018 Port 1 source priority: alu1 if valid, else FIFO head; port 2: alu2 if valid, else next FIFO entry (head if port 1 took alu1, head+1 otherwise).
REQ-019 Up to two FIFO pops per cycle; push and pop(s) in same cycle legal, count updates by +push-pops.
REQ-020 Writes to register 0 are never issued: WE deasserted, FIFO entries with mem_reg=0 are not pushed (mem_ready still honoured).
REQ-021 Same-cycle WAW: if both ports target one register, port 2 (younger) wins, WE1 forced 0.
REQ-022 Hazard unit guarantees an ALU write to a register with pending_mask set is younger; any buffered load whose register matches a valid alu1/alu2 destination is cancelled (entry marked dead, popped without write, not using a port).
REQ-023 Dead entries at FIFO head are discarded at up to two per cycle without consuming write ports.
REQ-024 pending_mask = OR over live entries; updated same edge as push/pop/cancel.
REQ-025 FSM states NORMAL, DRAIN. NORMAL: starve counter increments when FIFO has a live entry and both ALU valids are 1, clears otherwise; at STARVE_LIM go to DRAIN, stall_alu=1 for exactly one cycle, counter cleared. DRAIN returns to NORMAL next cycle.
REQ-026 Counter saturates; no wrap. FIFO pointers wrap modulo FIFO_DEPTH.
REQ-027 Overflow impossible by REQ-017; push while full is ignored.

Reset
REQ-028 While rst_n=0: WE1=WE2=0, WriteReg*=0, ResultW*=0, mem_ready=0, pending_mask=0, stall_alu=0, FIFO empty, counter 0, state NORMAL.
REQ-029 Reset mid-operation discards all buffered loads; mem_ready=1 on first edge after release.

Verification
REQ-030 alu1 r3=0x11, alu2 r4=0x22 same cycle -> next cycle WE1/WE2=1, regs 3/4, data 0x11/0x22.
REQ-031 alu1 and alu2 both r5 (0xA, 0xB) -> WE1=0, WE2=1, WriteReg2=5, ResultW2=0xB.
REQ-032 Four loads r1..r4 while both ALUs busy -> mem_ready=0 after fourth, pending_mask=0x1E; ALUs idle -> two writes/cycle, empty in 2 cycles, mask 0.
REQ-033 Load r6 buffered, alu1 writes r6=0x99 -> entry cancelled, only 0x99 written, pending_mask[6]=0.
REQ-034 Live load buffered, both ALUs valid 8 cycles -> stall_alu pulses one cycle; load written next cycle.
REQ-035 rst_n low with 3 buffered loads -> all outputs 0 immediately; no write after release.
